// File: rtl/tri_fb_sram.sv
// tri_fb_sram: 1-bit-per-pixel framebuffer held in an external 256Kx16 async SRAM.
// After reset an init FSM rasterises a right triangle into the SRAM, one 16-pixel word per
// three clocks. It then switches to read mode and returns the stored bit for (px, py).
//
// Ports:
//   CLOCK_50   - system clock, rising edge
//   KEY[0]     - asynchronous active-low reset
//   px, py     - pixel coordinate from the VGA timing top
//   pixel      - registered framebuffer bit for (px, py), two clocks after px/py
//   ready      - high once init has finished and read mode is active
//   SRAM_*     - async SRAM interface (DQ driven only during the write states)
module tri_fb_sram #(
    parameter int unsigned FB_W   = 320,
    parameter int unsigned FB_H   = 240,
    parameter int unsigned TRI_X0 = 40,
    parameter int unsigned TRI_Y0 = 20,
    parameter int unsigned TRI_H  = 200
) (
    input  logic        CLOCK_50,
    input  logic [0:0]  KEY,
    input  logic [8:0]  px,
    input  logic [8:0]  py,
    output logic        pixel,
    output logic        ready,
    output logic [17:0] SRAM_ADDR,
    inout  wire  [15:0] SRAM_DQ,
    output logic        SRAM_WE_N,
    output logic        SRAM_OE_N,
    output logic        SRAM_UB_N,
    output logic        SRAM_LB_N,
    output logic        SRAM_CE_N
);

    localparam int unsigned WordsPerRow = FB_W / 16;
    localparam int unsigned ColW        = (WordsPerRow > 1) ? $clog2(WordsPerRow) : 1;
    localparam int unsigned RowW        = (FB_H > 1) ? $clog2(FB_H) : 1;
    localparam logic [ColW-1:0] LastCol = ColW'(WordsPerRow - 1);
    localparam logic [RowW-1:0] LastRow = RowW'(FB_H - 1);

    typedef enum logic [2:0] {
        StWSetup,
        StWPulse,
        StWHold,
        StRdWait,
        StRead
    } state_e;

    logic rst_n;
    assign rst_n = KEY[0];

    state_e          state_q, state_d;
    logic [ColW-1:0] wcol_q, wcol_d;
    logic [RowW-1:0] wrow_q, wrow_d;
    logic            ready_q, ready_d;
    logic            pixel_q, pixel_d;
    logic [17:0]     rd_addr_q, rd_addr_d;
    logic [3:0]      bitidx_q, bitidx_d;
    logic            inrange_q, inrange_d;

    logic            write_phase;
    logic [17:0]     waddr;
    logic [15:0]     wdata;
    logic [17:0]     raddr;
    logic            in_range;

    // Triangle membership. Range checks come first so the subtractions cannot wrap.
    function automatic logic tri_bit(input logic [9:0] x, input logic [9:0] y);
        logic in_rows;
        logic in_cols;
        in_rows = (y >= 10'(TRI_Y0)) && (y < 10'(TRI_Y0 + TRI_H));
        in_cols = (x >= 10'(TRI_X0));
        return in_rows && in_cols && ((x - 10'(TRI_X0)) <= (y - 10'(TRI_Y0)));
    endfunction

    // ------------------------------------------------------------------
    // Write side: address and data depend only on wcol/wrow, which only
    // advance on leaving W_HOLD, so both stay stable across all three states.
    // ------------------------------------------------------------------
    assign write_phase = (state_q == StWSetup) || (state_q == StWPulse) || (state_q == StWHold);
    assign waddr       = 18'(wrow_q) * 18'(WordsPerRow) + 18'(wcol_q);

    always_comb begin
        wdata = '0;
        for (int i = 0; i < 16; i++) begin
            // Bit 0 is the leftmost pixel of the word.
            wdata[i] = tri_bit((10'(wcol_q) << 4) | 10'(i), 10'(wrow_q));
        end
    end

    always_comb begin
        state_d = state_q;
        wcol_d  = wcol_q;
        wrow_d  = wrow_q;
        case (state_q)
            StWSetup: state_d = StWPulse;
            StWPulse: state_d = StWHold;
            StWHold: begin
                if (wcol_q == LastCol) begin
                    if (wrow_q == LastRow) begin
                        state_d = StRdWait;
                    end else begin
                        wcol_d  = '0;
                        wrow_d  = wrow_q + 1'b1;
                        state_d = StWSetup;
                    end
                end else begin
                    wcol_d  = wcol_q + 1'b1;
                    state_d = StWSetup;
                end
            end
            StRdWait: state_d = StRead;
            StRead:   state_d = StRead;
            default:  state_d = StWSetup;
        endcase
    end

    // ------------------------------------------------------------------
    // Read side: stage 1 registers the clamped address, bit index and range
    // flag; stage 2 picks the bit off the bus.
    // ------------------------------------------------------------------
    assign in_range = (10'(px) < 10'(FB_W)) && (10'(py) < 10'(FB_H));
    assign raddr    = 18'(py) * 18'(WordsPerRow) + 18'(px[8:4]);

    always_comb begin
        ready_d   = (state_d == StRead);
        rd_addr_d = rd_addr_q;
        bitidx_d  = bitidx_q;
        inrange_d = inrange_q;
        pixel_d   = pixel_q;
        if (state_q == StRead) begin
            // Out-of-range coordinates fetch word 0 so the address stays inside the image.
            rd_addr_d = in_range ? raddr : 18'd0;
            bitidx_d  = px[3:0];
            inrange_d = in_range;
            pixel_d   = inrange_q ? SRAM_DQ[bitidx_q] : 1'b0;
        end
    end

    always_ff @(posedge CLOCK_50 or negedge rst_n) begin
        if (!rst_n) begin
            state_q   <= StWSetup;
            wcol_q    <= '0;
            wrow_q    <= '0;
            ready_q   <= 1'b0;
            pixel_q   <= 1'b0;
            rd_addr_q <= '0;
            bitidx_q  <= '0;
            inrange_q <= 1'b0;
        end else begin
            state_q   <= state_d;
            wcol_q    <= wcol_d;
            wrow_q    <= wrow_d;
            ready_q   <= ready_d;
            pixel_q   <= pixel_d;
            rd_addr_q <= rd_addr_d;
            bitidx_q  <= bitidx_d;
            inrange_q <= inrange_d;
        end
    end

    // ------------------------------------------------------------------
    // SRAM pins. The DQ driver is also gated by reset so the bus releases
    // the instant KEY[0] falls, even though the reset state is W_SETUP.
    // ------------------------------------------------------------------
    assign SRAM_ADDR = write_phase ? waddr : rd_addr_q;
    assign SRAM_DQ   = (write_phase && rst_n) ? wdata : 16'hzzzz;
    assign SRAM_WE_N = (state_q != StWPulse);
    assign SRAM_OE_N = !((state_q == StRdWait) || (state_q == StRead));
    assign SRAM_UB_N = 1'b0;
    assign SRAM_LB_N = 1'b0;
    assign SRAM_CE_N = 1'b0;

    assign pixel = pixel_q;
    assign ready = ready_q;

endmodule
